// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two-port requester side and the single-ported memory side of
//   the burst arbiter.
//
//   Requester side (2 ports, port i in bit i / slice [32i+31:32i]):
//     req, we, addr, wdata          requester -> arbiter
//     rdata, beat, beat_idx, done,  arbiter -> requester
//     busy
//   Memory side:
//     mem_ren, mem_wen, mem_addr,   arbiter -> memory
//     mem_din
//     mem_dout                      memory -> arbiter (1-cycle registered read)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (caches plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [1:0]       req;
    logic [1:0]       we;
    logic [63:0]      addr;
    logic [63:0]      wdata;
    logic [31:0]      rdata;
    logic [1:0]       beat;
    logic [IDX_W-1:0] beat_idx;
    logic [1:0]       done;
    logic             busy;

    logic             mem_ren;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_din;
    logic [31:0]      mem_dout;

    modport slave (
        input  req, we, addr, wdata, mem_dout,
        output rdata, beat, beat_idx, done, busy,
        output mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req, we, addr, wdata, mem_dout,
        input  rdata, beat, beat_idx, done, busy,
        input  mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester burst arbiter in front of a single-ported word memory.
//   Port 0 is the I-cache, port 1 the D-cache. Each grant moves one full,
//   line-aligned cache line of LINE_WORDS words: a fill (read) or a
//   writeback (write). Grants are round-robin between the two ports.
//
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset
//     bus   - mem_arbiter_if.slave (requester handshake and memory bus)
//
//   Parameters:
//     LINE_WORDS - words per burst, power of two, 2..16
//     IDX_W      - beat index width, derived, do not override
//
//   Build option:
//     MEM_ARB_FIXED_PRIO_EN - when defined, port 1 always wins simultaneous
//                             requests and the round-robin pointer is ignored.
//
//   State | meaning
//   ------+----------------------------------------------------------------
//   IDLE     | waiting for req; grants in the same cycle a request is seen
//   RD_ISSUE | one mem_ren per cycle for beats 0..LINE_WORDS-1; data for the
//            | previous issue returns in the same cycle
//   RD_DRAIN | last read word returns, done pulses
//   WR       | one mem_wen per cycle, beat strobes the word being consumed
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t           state;
    logic             port;
    logic             wr_burst;
    logic [31:0]      base;
    logic [IDX_W-1:0] remain;
    logic             last_grant;

    logic [1:0]       beat_q;
    logic [1:0]       done_q;
    logic [IDX_W-1:0] beat_idx_q;
    logic             busy_q;
    logic             mem_ren_q;
    logic             mem_wen_q;
    logic [31:0]      mem_addr_q;

    logic             gnt_valid;
    logic             gnt_port;
    logic             gnt_we;
    logic [31:0]      gnt_addr;
    logic [31:0]      gnt_base;
    logic [1:0]       gnt_mask;
    logic [1:0]       port_mask;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] next_idx;
    logic [31:0]      wdata_sel;
    logic             rd_beat;

    // Grant selection, evaluated every cycle but only acted on in IDLE.
    always_comb begin
        gnt_valid = |bus.req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt_port = bus.req[1];
`else
        if (&bus.req) begin
            gnt_port = ~last_grant;
        end else begin
            gnt_port = bus.req[1];
        end
`endif
        gnt_addr = gnt_port ? bus.addr[63:32] : bus.addr[31:0];
        gnt_we   = bus.we[gnt_port];
        // Low address bits are dropped so every burst is line-aligned.
        gnt_base = gnt_addr & ~32'(LINE_WORDS - 1);
        gnt_mask = gnt_port ? 2'b10 : 2'b01;
    end

    assign port_mask = port ? 2'b10 : 2'b01;

    // The beat counter runs down; the word index is recovered from it.
    assign cur_idx  = IDX_W'(LINE_WORDS - 1) - remain;
    assign next_idx = cur_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            port       <= 1'b0;
            wr_burst   <= 1'b0;
            base       <= '0;
            remain     <= '0;
            last_grant <= 1'b1;
            beat_q     <= '0;
            done_q     <= '0;
            beat_idx_q <= '0;
            busy_q     <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            beat_q    <= '0;
            done_q    <= '0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        port       <= gnt_port;
                        wr_burst   <= gnt_we;
                        base       <= gnt_base;
                        last_grant <= gnt_port;
                        remain     <= IDX_W'(LINE_WORDS - 1);
                        busy_q     <= 1'b1;
                        mem_addr_q <= gnt_base;
                        if (gnt_we) begin
                            state      <= WR;
                            mem_wen_q  <= 1'b1;
                            beat_q     <= gnt_mask;
                            beat_idx_q <= '0;
                        end else begin
                            state     <= RD_ISSUE;
                            mem_ren_q <= 1'b1;
                        end
                    end
                end

                RD_ISSUE: begin
                    // Word issued this cycle is returned by memory next cycle.
                    beat_q     <= port_mask;
                    beat_idx_q <= cur_idx;
                    if (remain == '0) begin
                        state  <= RD_DRAIN;
                        done_q <= port_mask;
                    end else begin
                        mem_ren_q  <= 1'b1;
                        mem_addr_q <= base + 32'(next_idx);
                        remain     <= remain - IDX_W'(1);
                    end
                end

                RD_DRAIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                WR: begin
                    if (remain == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        mem_wen_q  <= 1'b1;
                        mem_addr_q <= base + 32'(next_idx);
                        beat_q     <= port_mask;
                        beat_idx_q <= next_idx;
                        remain     <= remain - IDX_W'(1);
                        if (remain == IDX_W'(1)) begin
                            done_q <= port_mask;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Write data is taken live from the granted requester, which advances
    // its word on each beat; a registered copy would lag by one word.
    assign wdata_sel = port ? bus.wdata[63:32] : bus.wdata[31:0];

    // Read data comes straight from the memory's registered output, qualified
    // by the registered beat strobe.
    assign rd_beat = (|beat_q) & ~wr_burst;

    assign bus.rdata    = rd_beat ? bus.mem_dout : '0;
    assign bus.beat     = beat_q;
    assign bus.beat_idx = beat_idx_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.mem_ren  = mem_ren_q;
    assign bus.mem_wen  = mem_wen_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_wen_q ? wdata_sel : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Requester processes play out queued
//   cache-line transactions per port; a transaction-level model predicts the
//   grant order, addresses, data and burst spacing, and a negedge monitor
//   compares every beat and memory strobe against the predicted queues.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_WORDS(LW)) bus ();

    mem_arbiter #(.LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        tb_req   [2];
    logic        tb_we    [2];
    logic [31:0] tb_addr  [2];
    logic [31:0] tb_wdata [2];

    assign bus.req   = {tb_req[1], tb_req[0]};
    assign bus.we    = {tb_we[1], tb_we[0]};
    assign bus.addr  = {tb_addr[1], tb_addr[0]};
    assign bus.wdata = {tb_wdata[1], tb_wdata[0]};

    // Environment memory: 256 words, aliased on the low address byte.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] mem_dout_r = 32'h0;
    assign bus.mem_dout = mem_dout_r;

    always @(posedge clk) begin
        if (bus.mem_ren) mem_dout_r <= mem[bus.mem_addr[7:0]];
        if (bus.mem_wen) mem[bus.mem_addr[7:0]] = bus.mem_din;
    end

    typedef struct packed {
        logic             wr;
        logic [31:0]      addr;
        logic [LW*32-1:0] wd;
    } tx_t;

    typedef struct packed {
        logic          port;
        logic          wr;
        logic [IW-1:0] idx;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    gap;
    } exp_t;

    tx_t         txq0 [$];
    tx_t         txq1 [$];
    exp_t        exp_q [$];
    logic [31:0] ren_q [$];

    int checks    = 0;
    int failures  = 0;
    bit mon_en    = 1'b0;
    int cyc       = 0;
    int last_done = 0;
    bit m_last    = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Transaction-level reference: grant order from the arbitration rule,
    // then every word of each line in order against a reference memory.
    function automatic void predict();
        tx_t         q0 [$];
        tx_t         q1 [$];
        tx_t         t;
        exp_t        e;
        logic [31:0] base;
        bit          p;
        bit          first;
        first = 1'b1;
        q0 = txq0;
        q1 = txq1;
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                p = 1'b1;
`else
                p = ~m_last;
`endif
            end else begin
                p = (q1.size() > 0);
            end
            m_last = p;
            t = p ? q1.pop_front() : q0.pop_front();
            base = (t.addr / LW) * LW;
            for (int k = 0; k < LW; k++) begin
                e.port = p;
                e.wr   = t.wr;
                e.idx  = IW'(k);
                e.addr = base + 32'(k);
                if (t.wr) begin
                    e.data = t.wd[k*32 +: 32];
                    ref_mem[e.addr[7:0]] = e.data;
                end else begin
                    e.data = ref_mem[e.addr[7:0]];
                    ren_q.push_back(e.addr);
                end
                e.gap = (k == 0 && !first) ? (t.wr ? 4'd2 : 4'd3) : 4'd0;
                exp_q.push_back(e);
            end
            first = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            chk("strobe_excl", 32'(bus.mem_ren & bus.mem_wen), 32'h0);
            if (bus.mem_ren) begin
                if (ren_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ren_unexpected actual addr=0x%0h required no read", bus.mem_addr);
                end else begin
                    chk("ren_addr", bus.mem_addr, ren_q.pop_front());
                end
            end
            if (|bus.beat) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected actual beat=%b required none", bus.beat);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_port", 32'(bus.beat), e.port ? 32'h2 : 32'h1);
                    chk("beat_idx", 32'(bus.beat_idx), 32'(e.idx));
                    chk("done", 32'(bus.done),
                        (e.idx == IW'(LW - 1)) ? (e.port ? 32'h2 : 32'h1) : 32'h0);
                    chk("busy_in_burst", 32'(bus.busy), 32'h1);
                    if (e.wr) begin
                        chk("wr_wen", 32'(bus.mem_wen), 32'h1);
                        chk("wr_addr", bus.mem_addr, e.addr);
                        chk("wr_data", bus.mem_din, e.data);
                    end else begin
                        chk("rd_data", bus.rdata, e.data);
                    end
                    if (e.idx == '0 && e.gap != 4'd0) begin
                        chk("burst_gap", 32'(cyc - last_done), 32'(e.gap));
                    end
                end
            end else begin
                chk("done_without_beat", 32'(bus.done), 32'h0);
            end
        end
        if (|bus.done) last_done = cyc;
    end

    function automatic int qsz(input int p);
        return (p == 0) ? txq0.size() : txq1.size();
    endfunction

    task automatic run_port(input int p);
        tx_t t;
        int  widx;
        int  guard;
        bit  b;
        bit  d;
        while (qsz(p) > 0) begin
            t = (p == 0) ? txq0[0] : txq1[0];
            tb_req[p]   = 1'b1;
            tb_we[p]    = t.wr;
            tb_addr[p]  = t.addr;
            tb_wdata[p] = t.wd[31:0];
            widx  = 0;
            guard = 0;
            d     = 1'b0;
            while (!d && guard < 100) begin
                @(negedge clk);
                b = bus.beat[p];
                d = bus.done[p];
                guard++;
                @(posedge clk);
                #1;
                if (b && !d) begin
                    widx++;
                    tb_wdata[p] = t.wd[widx*32 +: 32];
                    // Held inputs are disturbed mid-burst; the arbiter must ignore them.
                    if ($urandom_range(0, 2) == 0) begin
                        tb_req[p]  = 1'($urandom_range(0, 1));
                        tb_we[p]   = 1'($urandom_range(0, 1));
                        tb_addr[p] = $urandom;
                    end
                end
            end
            if (!d) begin
                checks++;
                failures++;
                $display("FAIL port%0d_timeout actual no done within %0d cycles required done", p, guard);
                if (p == 0) txq0.delete(); else txq1.delete();
            end else begin
                if (p == 0) void'(txq0.pop_front()); else void'(txq1.pop_front());
            end
        end
        tb_req[p] = 1'b0;
    endtask

    function automatic tx_t rand_tx();
        tx_t t;
        t.wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) t.addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                           t.addr = $urandom;
        for (int k = 0; k < LW; k++) t.wd[k*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic run_round();
        predict();
        fork
            run_port(0);
            run_port(1);
        join
        repeat (3) @(negedge clk);
        chk("round_beats_drained", 32'(exp_q.size()), 32'h0);
        chk("round_reads_drained", 32'(ren_q.size()), 32'h0);
        chk("busy_after_round", 32'(bus.busy), 32'h0);
        exp_q.delete();
        ren_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual time=%0t required finish earlier", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_t t;
        bit  found;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int p = 0; p < 2; p++) begin
            tb_req[p]   = 1'b0;
            tb_we[p]    = 1'b0;
            tb_addr[p]  = 32'h0;
            tb_wdata[p] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_beat", 32'(bus.beat), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_ren", 32'(bus.mem_ren), 32'h0);
        chk("rst_wen", 32'(bus.mem_wen), 32'h0);
        chk("rst_beat_idx", 32'(bus.beat_idx), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_din", bus.mem_din, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Fill of 0x13 on port 0 and writeback of 0xA0..0xA3 to 0x40 on port 1.
        t.wr = 1'b0; t.addr = 32'h13; t.wd = '0;
        txq0.push_back(t);
        t.wr = 1'b1; t.addr = 32'h40;
        for (int k = 0; k < LW; k++) t.wd[k*32 +: 32] = 32'hA0 + 32'(k);
        txq1.push_back(t);
        run_round();

        // Read the written line back.
        t.wr = 1'b0; t.addr = 32'h42; t.wd = '0;
        txq0.push_back(t);
        run_round();

        // Both ports continuously requesting.
        for (int i = 0; i < 3; i++) begin
            txq0.push_back(rand_tx());
            txq1.push_back(rand_tx());
        end
        run_round();

        // Reset in the middle of a port-0 fill.
        mon_en    = 1'b0;
        tb_req[0] = 1'b1;
        tb_we[0]  = 1'b0;
        tb_addr[0] = 32'h24;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.beat[0] && bus.beat_idx == IW'(2)) found = 1'b1;
        end
        chk("rst_test_reached_beat2", 32'(found), 32'h1);
        rst       = 1'b1;
        tb_req[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ren", 32'(bus.mem_ren), 32'h0);
        chk("midrst_beat", 32'(bus.beat), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(bus.done), 32'h0);
        end
        m_last = 1'b1;
        exp_q.delete();
        ren_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // After reset the tie goes to port 0 again.
        for (int i = 0; i < 2; i++) begin
            txq0.push_back(rand_tx());
            txq1.push_back(rand_tx());
        end
        run_round();

        // Randomised rounds.
        for (int r = 0; r < 12; r++) begin
            int n0;
            int n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) txq0.push_back(rand_tx());
            for (int i = 0; i < n1; i++) txq1.push_back(rand_tx());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_round();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
